// File: rtl/alu_muldiv.sv
// Multi-cycle WIDTH-bit execution unit: add/sub/and/or in one clock,
// unsigned mul/mulhu/divu/remu iterating one bit per clock behind Start/Busy/Done.
module alu_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state_q, state_d;
   logic               sel_q, sel_d;     // 1: mulhu/remu, 0: mul/divu
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
   logic [2*WIDTH-1:0] prod_q, prod_d;   // {accumulator, multiplier}
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifts out, quotient shifts in
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_d;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic               div_ge;

   // State and working registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         opnd_q    <= '0;
         prod_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         ALUResult <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         opnd_q    <= opnd_d;
         prod_q    <= prod_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         ALUResult <= res_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      opnd_d  = opnd_q;
      prod_d  = prod_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      res_d   = ALUResult;
      mul_sum = '0;
      div_sh  = '0;
      div_ge  = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               sel_d = ALUControl[0];
               cnt_d = '0;
               case (ALUControl)
                  3'b000: begin res_d = SrcA + SrcB; state_d = DONE; end
                  3'b001: begin res_d = SrcA - SrcB; state_d = DONE; end
                  3'b010: begin res_d = SrcA & SrcB; state_d = DONE; end
                  3'b011: begin res_d = SrcA | SrcB; state_d = DONE; end
                  3'b100, 3'b101: begin
                     opnd_d  = SrcA;
                     prod_d  = {{WIDTH{1'b0}}, SrcB};
                     state_d = MUL;
                  end
                  default: begin
                     if (SrcB == '0) begin
                        // divide by zero: quotient all ones, remainder = dividend
                        res_d   = ALUControl[0] ? SrcA : '1;
                        state_d = DONE;
                     end else begin
                        opnd_d  = SrcB;
                        rem_d   = '0;
                        quo_d   = SrcA;
                        state_d = DIV;
                     end
                  end
               endcase
            end
         end
         MUL: begin
            mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
            prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               res_d   = sel_q ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0];
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DIV: begin
            div_sh = {rem_q, quo_q[WIDTH-1]};
            div_ge = (div_sh >= {1'b0, opnd_q});
            rem_d  = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
            quo_d  = {quo_q[WIDTH-2:0], div_ge};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               res_d   = sel_q ? rem_d : quo_d;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign Zero = (ALUResult == '0);
   assign Busy = (state_q != IDLE);
   assign Done = (state_q == DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=8: vector table plus handshake and reset sequences.
module tb_alu_muldiv;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         Start;
   logic [2:0]   ALUControl;
   logic [W-1:0] SrcA, SrcB;
   logic [W-1:0] ALUResult;
   logic         Zero, Busy, Done;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      int           lat;
      string        nm;
   } vec_t;

   vec_t vecs[$];

   alu_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl),
      .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult),
      .Zero(Zero), .Busy(Busy), .Done(Done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input int lat, input string nm);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat; v.nm = nm;
      vecs.push_back(v);
   endtask

   // Issue one op (caller is just after a posedge), wait for Done, check everything.
   task automatic run_op(input vec_t v);
      int lat    = 0;
      int busy_n = 0;
      ALUControl = v.op; SrcA = v.a; SrcB = v.b; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      ALUControl = 3'($urandom); SrcA = W'($urandom); SrcB = W'($urandom);
      for (int k = 1; k <= 20; k++) begin
         if (Busy) busy_n++;
         if (Done) begin lat = k; break; end
         @(posedge clk); #1;
      end
      chk({v.nm, " latency"}, 32'(lat), 32'(v.lat));
      chk({v.nm, " result"}, 32'(ALUResult), 32'(v.res));
      chk({v.nm, " zero"}, 32'(Zero), 32'(v.res == '0));
      chk({v.nm, " busy cycles"}, 32'(busy_n), 32'(v.lat));
      @(posedge clk); #1;
      chk({v.nm, " idle after done"}, {30'd0, Busy, Done}, 32'd0);
   endtask

   initial begin
      int done_n;
      vec_t v;

      add_vec(3'b000, 8'h0C, 8'h0C, 8'h18, 1, "add");
      add_vec(3'b001, 8'h0C, 8'h01, 8'h0B, 1, "sub");
      add_vec(3'b010, 8'h0C, 8'h2D, 8'h0C, 1, "and");
      add_vec(3'b011, 8'h4C, 8'h0C, 8'h4C, 1, "or");
      add_vec(3'b000, 8'hFF, 8'h02, 8'h01, 1, "add wrap");
      add_vec(3'b100, 8'd13, 8'd11, 8'h8F, 9, "mul 13x11");
      add_vec(3'b101, 8'd200, 8'd200, 8'h9C, 9, "mulhu 200x200");
      add_vec(3'b100, 8'hFF, 8'hFF, 8'h01, 9, "mul ffxff");
      add_vec(3'b101, 8'hFF, 8'hFF, 8'hFE, 9, "mulhu ffxff");
      add_vec(3'b110, 8'd100, 8'd7, 8'h0E, 9, "divu 100/7");
      add_vec(3'b111, 8'd100, 8'd7, 8'h02, 9, "remu 100/7");
      add_vec(3'b001, 8'h05, 8'h05, 8'h00, 1, "sub zero");
      add_vec(3'b110, 8'h07, 8'd100, 8'h00, 9, "divu 7/100");
      add_vec(3'b111, 8'h07, 8'd100, 8'h07, 9, "remu 7/100");
      add_vec(3'b110, 8'hFF, 8'h01, 8'hFF, 9, "divu ff/1");
      add_vec(3'b110, 8'h05, 8'h00, 8'hFF, 1, "divu by 0");
      add_vec(3'b111, 8'h05, 8'h00, 8'h05, 1, "remu by 0");

      reset = 1'b1; Start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
      #12;
      chk("reset result", 32'(ALUResult), 32'd0);
      chk("reset flags", {29'd0, Zero, Busy, Done}, 32'b100);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) run_op(vecs[i]);

      // Start pulses at edge 3 and edge 9 (DONE cycle) of a mul must be ignored
      ALUControl = 3'b100; SrcA = 8'd13; SrcB = 8'd11; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; done_n = 0;
      for (int k = 1; k <= 9; k++) begin
         if (k == 3 || k == 9) begin
            ALUControl = 3'b000; SrcA = 8'h01; SrcB = 8'h01; Start = 1'b1;
         end
         @(posedge clk); #1;
         Start = 1'b0;
         if (Done) done_n++;
         if (k == 3) chk("hs result held at edge3", 32'(ALUResult), 32'h05);
         if (k == 8) chk("hs done at edge8", {31'd0, Done}, 32'd1);
      end
      chk("hs done count", 32'(done_n), 32'd1);
      chk("hs idle after done", {31'd0, Busy}, 32'd0);
      chk("hs mul result", 32'(ALUResult), 32'h8F);
      v.op = 3'b000; v.a = 8'h03; v.b = 8'h04; v.res = 8'h07; v.lat = 1; v.nm = "hs add after done";
      run_op(v);

      // Reset in the middle of a divu aborts with no Done
      ALUControl = 3'b110; SrcA = 8'd100; SrcB = 8'd7; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("abort result", 32'(ALUResult), 32'd0);
      chk("abort flags", {29'd0, Zero, Busy, Done}, 32'b100);
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      done_n = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (Done || Busy) done_n++;
      end
      chk("no done after abort", 32'(done_n), 32'd0);
      v.op = 3'b000; v.a = 8'h01; v.b = 8'h02; v.res = 8'h03; v.lat = 1; v.nm = "add after reset";
      run_op(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle successor to the single-cycle N-bit ALU: a WIDTH-bit execution unit that adds unsigned multiply and divide to add/sub/and/or. Single-cycle ops return after one clock. Multiply and divide iterate one bit per clock behind a Start/Busy/Done handshake. It sits in the execute stage; control stalls the core while Busy is high.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  request a new operation; sampled only when Busy=0.
- ALUControl  in  3  operation select: 000 add, 001 sub, 010 and, 011 or, 100 mul (low WIDTH bits), 101 mulhu (high WIDTH bits, unsigned), 110 divu, 111 remu.
- SrcA  in  WIDTH  operand A / dividend / multiplicand.
- SrcB  in  WIDTH  operand B / divisor / multiplier.
- ALUResult  out  WIDTH  registered result; holds its value until the next Done.
- Zero  out  1  high when ALUResult == 0.
- Busy  out  1  high whenever the FSM is not IDLE.
- Done  out  1  one-cycle pulse when ALUResult is updated.

## Operation
- FSM states are IDLE, MUL, DIV and DONE.
- IDLE with Start=1:
  - SrcA, SrcB and ALUControl are latched at this edge.
  - Ops 000–011: the result is computed and registered at this edge; next state is DONE.
  - Ops 100 and 101: load the product accumulator (2·WIDTH bits) and the multiplier; next state is MUL.
  - Ops 110 and 111 with SrcB≠0: load the remainder and quotient registers; next state is DIV.
  - Ops 110 and 111 with SrcB=0 (fast path): divu gives all ones, remu gives SrcA; next state is DONE.
- MUL: shift-add, one multiplier bit per clock, WIDTH iterations driven by a bit counter. On the last iteration, write the low half (mul) or high half (mulhu) of the product to ALUResult and go to DONE.
- DIV: restoring division, one quotient bit per clock, WIDTH iterations. On the last iteration, write the quotient (divu) or remainder (remu) to ALUResult and go to DONE.
- DONE: Done=1 and Busy=1; next state is IDLE unconditionally.
- Start is ignored whenever Busy=1, including in the DONE cycle. No queuing.
- Arithmetic rules:
  - add and sub wrap modulo 2^WIDTH; no carry or overflow output.
  - Multiply and divide are unsigned only.
  - divu/remu by zero follow the RISC-V M convention.
- Inputs may change freely after the Start edge; the latched copies are used.

## Timing
- Reset values: state IDLE, ALUResult 0, Zero 1, Busy 0, Done 0, counters and working registers 0.
- Call the edge that accepts Start edge 0.
- Single-cycle ops and the div-by-zero fast path: ALUResult is valid and Done=1 in the cycle after edge 0 (latency 1). Busy=1 for that one cycle.
- Multiply and divide:
  - Iterations occur on edges 1..WIDTH.
  - ALUResult is valid and Done=1 in the cycle after edge WIDTH (latency WIDTH+1 from Start).
  - Busy=1 for WIDTH+1 cycles.
- Back-to-back throughput: a new Start can be accepted in the cycle after Done, since the FSM is back in IDLE. The minimum issue interval is 2 cycles for single-cycle ops and WIDTH+2 cycles for multiply/divide.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values, and no Done is produced for the aborted operation.
- Zero is combinational from the ALUResult register only, so it changes exactly when ALUResult changes.
- ALUControl values are fully decoded; there are no undefined codes.

## Test plan
All scenarios use WIDTH=8.
- Simple ops:
  - add 0x0C+0x0C gives 0x18.
  - sub 0x0C−0x01 gives 0x0B.
  - and 0x0C&0x2D gives 0x0C.
  - or 0x4C|0x0C gives 0x4C.
  - Each: Done one cycle after Start, Busy high for exactly 1 cycle, Zero=0.
- Multiply:
  - mul 13×11 gives 0x8F.
  - mulhu 200×200 (0x9C40) gives 0x9C.
  - Each: Done exactly 9 cycles after the Start edge, Busy high for 9 cycles.
- Divide:
  - divu 100/7 gives 0x0E.
  - remu 100/7 gives 0x02.
  - Each: latency 9.
  - Also: sub 5−5 gives 0x00 with Zero=1.
- Divide by zero:
  - divu 5/0 gives 0xFF.
  - remu 5/0 gives 0x05.
  - Each: Done one cycle after Start.
- Handshake: during a mul, pulse Start with an add at cycles 3 and 9 (the DONE cycle). Both are ignored; ALUResult shows only the mul result. An add issued in the cycle after Done is accepted.
- Reset: assert reset at cycle 4 of a divu.
  - Busy, Done and ALUResult drop to 0 and Zero goes to 1 asynchronously.
  - No Done pulse follows.
  - A fresh add 1+2 after reset gives 0x03.
